// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry type for the instruction-fetch stage.
package fetch_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_INSTR_W = 16;
   localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 16'h0000;
   localparam logic [DEF_ADDR_W-1:0] DEF_PC_INC = 16'h0001;

   typedef struct packed {
      logic [DEF_INSTR_W-1:0] instr;
      logic [DEF_ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small first-word-fall-through FIFO with synchronous clear; head is readable without a pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited request issue, prefetch queue
// and redirect handling with discard of stale in-flight responses.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSTR_W  = DEF_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
   parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(DEF_PC_INC),
   parameter int                QDEPTH   = 4,
   parameter int                CNT_W    = $clog2(QDEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  out_pcplus1
);
   localparam int ENTRY_W = INSTR_W + ADDR_W;
   localparam int SUM_W   = CNT_W + 1;

   logic [ADDR_W-1:0]  fetch_pc_reg, fetch_pc_next;
   logic [CNT_W-1:0]   outstanding_reg, outstanding_next;
   logic [CNT_W-1:0]   drop_reg, drop_next;
   logic [CNT_W-1:0]   q_count, tag_count;
   logic               q_full, q_empty, tag_full, tag_empty;
   logic [ADDR_W-1:0]  tag_head;
   logic [ENTRY_W-1:0] q_head;
   logic [SUM_W-1:0]   credit_used;
   logic               fire, resp, dropping, q_push, q_pop;
   logic               unused_ok;

   // Queue entries plus in-flight requests never exceed QDEPTH, so every response has a slot.
   assign credit_used = SUM_W'(q_count) + SUM_W'(outstanding_reg);
   assign imem_req    = !rst && !redirect_valid && (credit_used < SUM_W'(QDEPTH));
   assign imem_addr   = fetch_pc_reg;
   assign fire        = imem_req && imem_gnt;
   assign resp        = imem_rvalid && !tag_empty;
   assign dropping    = resp && (drop_reg != '0);
   assign q_push      = resp && !dropping && !redirect_valid && !rst;

   assign out_valid   = !rst && !redirect_valid && !q_empty;
   assign q_pop       = out_valid && out_ready;
   assign out_instr   = q_head[ENTRY_W-1:ADDR_W];
   assign out_pc      = q_head[ADDR_W-1:0];
   assign out_pcplus1 = out_pc + PC_INC;

   assign unused_ok   = &{1'b0, q_full, tag_full, tag_count};

   always_comb begin
      outstanding_next = outstanding_reg + CNT_W'(fire) - CNT_W'(resp);
      fetch_pc_next    = fetch_pc_reg;
      drop_next        = drop_reg - CNT_W'(dropping);
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_next = redirect_pc;
         drop_next     = outstanding_next;
      end else if (fire) begin
         fetch_pc_next = fetch_pc_reg + PC_INC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg    <= RESET_PC;
         outstanding_reg <= '0;
         drop_reg        <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         outstanding_reg <= outstanding_next;
         drop_reg        <= drop_next;
      end
   end

   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(QDEPTH)) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (1'b0),
      .push      (fire),
      .push_data (fetch_pc_reg),
      .pop       (resp),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(QDEPTH)) u_instr_q (
      .clk       (clk),
      .rst       (rst),
      .clr       (redirect_valid),
      .push      (q_push),
      .push_data ({imem_rdata, tag_head}),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

endmodule
